fft_sequencer: RTL and testbench

FFT_SEQUENCER -- requirements
Module: fft_sequencer

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_wb_delay.sv | 31 +++
 rtl/fft_sequencer.sv | 154 +++++++++++++++
 tb/tb_fft_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sequencer state encoding and the load-order address permutation
// used by the 32-point radix-2 FFT sequencer.
package fft_pkg;

   localparam int N              = 32;
   localparam int LOG2N          = 5;
   localparam int BFLY_PER_STAGE = N / 2;
   localparam int LAST_STAGE     = LOG2N - 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMPUTE,
      DRAIN,
      UNLOAD
   } state_t;

   // Samples land in bit-reversed slots so the in-place DIT passes leave results in natural order.
   function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] x);
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Fixed-depth delay line that carries butterfly issue info to the write-back port.
// Cleared asynchronously so an aborted transform can never emit a late write.
module fft_wb_delay #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [DEPTH-1:0][WIDTH-1:0] pipe;

   generate
      if (DEPTH == 1) begin : g_one
         always_ff @(posedge clk or posedge reset) begin
            if (reset) pipe <= '0;
            else       pipe[0] <= d;
         end
      end else begin : g_many
         always_ff @(posedge clk or posedge reset) begin
            if (reset) pipe <= '0;
            else       pipe <= {pipe[DEPTH-2:0], d};
         end
      end
   endgenerate

   assign q = pipe[DEPTH-1];

endmodule

// File: rtl/fft_sequencer.sv
// Control sequencer for an in-place 32-point radix-2 FFT: loads samples in bit-reversed
// order, issues 5 stages of 16 butterflies with write-back drain, then unloads in order.
module fft_sequencer
   import fft_pkg::*;
#(
   parameter int BFLY_LAT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             load_we,
   output logic [LOG2N-1:0] load_addr,
   output logic             bfly_issue,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [3:0]       twiddle_addr,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b,
   output logic [2:0]       stage,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LOG2N-1:0] out_addr,
   output logic             out_last
);

   localparam logic [3:0]       DRAIN_LAST = 4'(BFLY_LAT - 1);
   localparam logic [3:0]       J_LAST     = 4'(BFLY_PER_STAGE - 1);
   localparam logic [LOG2N-1:0] K_LAST     = LOG2N'(N - 1);
   localparam logic [2:0]       S_LAST     = 3'(LAST_STAGE);

   state_t           state, state_nxt;
   logic [2:0]       stage_q;
   logic [3:0]       j_q;
   logic [LOG2N-1:0] k_q;
   logic [3:0]       d_q;
   logic             done_q;

   logic [LOG2N-1:0] bf_h, bf_lo, bf_hi;
   logic [2*LOG2N:0] wb_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Butterfly j of stage s pairs (j>>s)*2h + j%h with its partner h above; h = 2^s.
   always_comb begin
      bf_h  = LOG2N'(1) << stage_q;
      bf_lo = {1'b0, j_q} & (bf_h - LOG2N'(1));
      bf_hi = ({1'b0, j_q} >> stage_q) << (stage_q + 3'd1);
   end

   always_comb begin
      state_nxt    = state;
      busy         = 1'b0;
      in_ready     = 1'b0;
      load_we      = 1'b0;
      load_addr    = '0;
      bfly_issue   = 1'b0;
      rd_addr_a    = '0;
      rd_addr_b    = '0;
      twiddle_addr = '0;
      out_valid    = 1'b0;
      out_addr     = '0;
      out_last     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            busy      = 1'b1;
            in_ready  = 1'b1;
            load_we   = in_valid;
            load_addr = bitrev5(k_q);
            if (in_valid && k_q == K_LAST) state_nxt = COMPUTE;
         end
         COMPUTE: begin
            busy         = 1'b1;
            bfly_issue   = 1'b1;
            rd_addr_a    = bf_hi | bf_lo;
            rd_addr_b    = bf_hi | bf_lo | bf_h;
            twiddle_addr = 4'(bf_lo << (3'd4 - stage_q));
            if (j_q == J_LAST) state_nxt = DRAIN;
         end
         DRAIN: begin
            // Hold off the next stage until the last write-back of this one has landed.
            busy = 1'b1;
            if (d_q == DRAIN_LAST) state_nxt = (stage_q == S_LAST) ? UNLOAD : COMPUTE;
         end
         UNLOAD: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_addr  = k_q;
            out_last  = (k_q == K_LAST);
            if (out_ready && k_q == K_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // k is shared by LOAD and UNLOAD; the natural 5-bit rollover clears it on phase exit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_q <= '0;
         j_q     <= '0;
         k_q     <= '0;
         d_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= (state == UNLOAD) && out_ready && (k_q == K_LAST);
         case (state)
            LOAD: begin
               if (in_valid) k_q <= k_q + LOG2N'(1);
            end
            COMPUTE: begin
               j_q <= j_q + 4'd1;
               d_q <= '0;
            end
            DRAIN: begin
               if (d_q == DRAIN_LAST) begin
                  d_q     <= '0;
                  stage_q <= (stage_q == S_LAST) ? 3'd0 : stage_q + 3'd1;
               end else begin
                  d_q <= d_q + 4'd1;
               end
            end
            UNLOAD: begin
               if (out_ready) k_q <= k_q + LOG2N'(1);
            end
            default: ;
         endcase
      end
   end

   fft_wb_delay #(
      .DEPTH (BFLY_LAT),
      .WIDTH (2*LOG2N + 1)
   ) u_wb_delay (
      .clk   (clk),
      .reset (reset),
      .d     ({bfly_issue, rd_addr_a, rd_addr_b}),
      .q     (wb_q)
   );

   assign {wr_en, wr_addr_a, wr_addr_b} = wb_q;
   assign stage = stage_q;
   assign done  = done_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer: full transforms, stalls, abort by reset and latency variants.
module tb_fft_sequencer;

   localparam int LAT  = 3;
   localparam int SLEN = 16 + LAT;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       busy, done, in_ready, load_we, bfly_issue, wr_en, out_valid, out_last;
   logic [4:0] load_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, out_addr;
   logic [3:0] twiddle_addr;
   logic [2:0] stage;
   logic [63:0] all_outs;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fft_sequencer #(.BFLY_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .load_we(load_we), .load_addr(load_addr),
      .bfly_issue(bfly_issue), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .twiddle_addr(twiddle_addr), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
      .stage(stage), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_last(out_last)
   );

   assign all_outs = {19'd0, busy, done, in_ready, load_we, load_addr, bfly_issue, rd_addr_a,
                      rd_addr_b, twiddle_addr, wr_en, wr_addr_a, wr_addr_b, stage, out_valid,
                      out_addr, out_last};

   // Latency variants: BFLY_LAT=1 (index 0) and BFLY_LAT=8 (index 1), always-ready streams.
   logic [1:0]      start_x = 2'b00;
   logic [1:0]      busy_x, done_x, iss_x, ov_x, ir_x, lw_x, we_x, ol_x;
   logic [1:0][4:0] la_x, ra_x, rb_x, wa_x, wb_x, oa_x;
   logic [1:0][3:0] tw_x;
   logic [1:0][2:0] st_x;

   fft_sequencer #(.BFLY_LAT(1)) u_lat1 (
      .clk(clk), .reset(reset), .start(start_x[0]), .busy(busy_x[0]), .done(done_x[0]),
      .in_valid(1'b1), .in_ready(ir_x[0]), .load_we(lw_x[0]), .load_addr(la_x[0]),
      .bfly_issue(iss_x[0]), .rd_addr_a(ra_x[0]), .rd_addr_b(rb_x[0]), .twiddle_addr(tw_x[0]),
      .wr_en(we_x[0]), .wr_addr_a(wa_x[0]), .wr_addr_b(wb_x[0]), .stage(st_x[0]),
      .out_valid(ov_x[0]), .out_ready(1'b1), .out_addr(oa_x[0]), .out_last(ol_x[0])
   );

   fft_sequencer #(.BFLY_LAT(8)) u_lat8 (
      .clk(clk), .reset(reset), .start(start_x[1]), .busy(busy_x[1]), .done(done_x[1]),
      .in_valid(1'b1), .in_ready(ir_x[1]), .load_we(lw_x[1]), .load_addr(la_x[1]),
      .bfly_issue(iss_x[1]), .rd_addr_a(ra_x[1]), .rd_addr_b(rb_x[1]), .twiddle_addr(tw_x[1]),
      .wr_en(we_x[1]), .wr_addr_a(wa_x[1]), .wr_addr_b(wb_x[1]), .stage(st_x[1]),
      .out_valid(ov_x[1]), .out_ready(1'b1), .out_addr(oa_x[1]), .out_last(ol_x[1])
   );

   // Bit-reversed load order, written out by hand.
   int br_tbl [32] = '{0,16,8,24,4,20,12,28,2,18,10,26,6,22,14,30,
                       1,17,9,25,5,21,13,29,3,19,11,27,7,23,15,31};
   // Spot butterflies per stage 0..3: {j, rd_addr_a, rd_addr_b, twiddle_addr}.
   int spot_tbl [4][4] = '{'{3,6,7,0}, '{3,5,7,8}, '{5,9,13,4}, '{13,21,29,10}};

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One transform on the main instance. stress: in_valid every other cycle and a 5-cycle
   // out_ready stall at k=10. Otherwise back-to-back, with a stray start pulse in stage 1.
   task automatic run_xform(input bit stress);
      bit       hist_iss [2048];
      int       hist_a [2048];
      int       hist_b [2048];
      int       iss_cnt [5];
      int       ld_n, un_k, wr_tot, load_end, last_hs, stall_left, rel, spot_cyc;
      bit       ld_done, fin, exp_iss, exp_ov, exp_wr, pulsed;
      ld_n = 0; un_k = 0; wr_tot = 0; load_end = 0; last_hs = -1; stall_left = 5;
      spot_cyc = -100; ld_done = 0; fin = 0; pulsed = 0;
      for (int s = 0; s < 5; s++) iss_cnt[s] = 0;
      @(negedge clk);
      start = 1'b1;
      #1 chk("idle_busy", busy, 0);
      @(negedge clk);
      for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
         if (cyc > 0) @(negedge clk);
         start     = 1'b0;
         in_valid  = stress ? (cyc % 2 == 0) : 1'b1;
         out_ready = 1'b1;
         #1;
         hist_iss[cyc] = bfly_issue;
         hist_a[cyc]   = rd_addr_a;
         hist_b[cyc]   = rd_addr_b;
         rel     = cyc - load_end;
         exp_iss = ld_done && rel < 5*SLEN && (rel % SLEN) < 16;
         exp_ov  = ld_done && rel >= 5*SLEN && un_k < 32;
         chk("in_ready", in_ready, ld_n < 32);
         chk("bfly_issue", bfly_issue, exp_iss);
         chk("out_valid", out_valid, exp_ov);
         chk("out_last", out_last, exp_ov && un_k == 31);
         if (in_ready) begin
            chk("load_we", load_we, in_valid);
            chk("load_addr", load_addr, br_tbl[ld_n]);
            if (in_valid) begin
               ld_n++;
               if (ld_n == 32) begin ld_done = 1; load_end = cyc + 1; end
            end
         end
         if (bfly_issue) begin
            if (iss_cnt[stage] == 0 && stage != 0) chk("order_wb", wr_tot, 16*stage);
            if (stage < 4 && iss_cnt[stage] == spot_tbl[stage][0]) begin
               chk("spot_a", rd_addr_a, spot_tbl[stage][1]);
               chk("spot_b", rd_addr_b, spot_tbl[stage][2]);
               chk("spot_tw", twiddle_addr, spot_tbl[stage][3]);
               if (stage == 2) spot_cyc = cyc;
            end
            if (stage == 4) begin
               chk("s4_a", rd_addr_a, iss_cnt[4]);
               chk("s4_b", rd_addr_b, iss_cnt[4] + 16);
               chk("s4_tw", twiddle_addr, iss_cnt[4]);
            end
            if (stage <= 4) iss_cnt[stage]++;
            if (!stress && !pulsed && stage == 1 && iss_cnt[1] == 4) begin
               start = 1'b1;
               pulsed = 1;
            end
         end
         exp_wr = (cyc >= LAT) ? hist_iss[cyc-LAT] : 1'b0;
         chk("wr_en", wr_en, exp_wr);
         if (wr_en && exp_wr) begin
            chk("wr_addr_a", wr_addr_a, hist_a[cyc-LAT]);
            chk("wr_addr_b", wr_addr_b, hist_b[cyc-LAT]);
            wr_tot++;
         end
         if (cyc == spot_cyc + LAT) begin
            chk("s2j5_wr_en", wr_en, 1);
            chk("s2j5_wr_a", wr_addr_a, 9);
            chk("s2j5_wr_b", wr_addr_b, 13);
         end
         if (out_valid) begin
            chk("out_addr", out_addr, un_k);
            if (stress && un_k == 10 && stall_left > 0) begin
               chk("hold10", out_addr, 10);
               out_ready = 1'b0;
               stall_left--;
            end
            if (out_ready) begin
               un_k++;
               last_hs = cyc;
            end
         end
         if (done) begin
            fin = 1;
            chk("done_idle", busy, 0);
            chk("done_after_last", cyc, last_hs + 1);
            if (!stress) chk("done_cycle", cyc, 32 + 5*SLEN + 32);
         end
      end
      chk("done_seen", fin, 1);
      chk("loads", ld_n, 32);
      chk("unloads", un_k, 32);
      chk("writes", wr_tot, 80);
      for (int s = 0; s < 5; s++) chk("issues_per_stage", iss_cnt[s], 16);
      if (stress) chk("stall_used", stall_left, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("done_pulse_1cyc", done, 0);
   endtask

   task automatic measure(input int idx, input int lat);
      int first_iss, first_ov, n_iss;
      bit got;
      first_iss = -1; first_ov = -1; n_iss = 0; got = 0;
      @(negedge clk);
      start_x[idx] = 1'b1;
      @(negedge clk);
      start_x[idx] = 1'b0;
      #1;
      for (int t = 0; t < 1000 && !got; t++) begin
         if (iss_x[idx]) n_iss++;
         if (iss_x[idx] && first_iss < 0) first_iss = t;
         if (ov_x[idx] && first_ov < 0) first_ov = t;
         if (done_x[idx]) begin
            got = 1;
            chk("lat_done_cycle", t, 64 + 5*(16 + lat));
         end
         if (!got) begin
            @(negedge clk);
            #1;
         end
      end
      chk("lat_done_seen", got, 1);
      chk("lat_compute_len", first_ov - first_iss, 5*(16 + lat));
      chk("lat_issues", n_iss, 80);
   endtask

   initial begin
      bit found;
      repeat (3) @(negedge clk);
      #1 chk("reset_outs", all_outs, 0);
      reset = 1'b0;
      @(negedge clk);
      #1 chk("post_reset_outs", all_outs, 0);

      run_xform(1'b0);
      run_xform(1'b1);

      // Abort in stage 3 drain.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      found = 0;
      for (int t = 0; t < 400 && !found; t++) begin
         #1;
         if (busy && stage == 3 && !bfly_issue) found = 1;
         else @(negedge clk);
      end
      chk("abort_reached", found, 1);
      reset = 1'b1;
      #1 chk("abort_outs", all_outs, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         #1;
         chk("abort_wr_en", wr_en, 0);
         chk("abort_done", done, 0);
         chk("abort_busy", busy, 0);
      end

      run_xform(1'b0);
      measure(0, 1);
      measure(1, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
